pe_pad_ctrl: RTL and testbench

PE_PAD_CTRL -- requirements
Module: pe_pad_ctrl

---
 rtl/pe_pad_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pe_pad_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_pad_ctrl.sv
// pe_pad_ctrl: sequences the pad control bus for one PE job.
// A configuration is latched in IDLE through a valid/ready handshake, then
// a start request runs the job: one o_pop per accepted WPAD end-of-Tm pulse,
// o_nxtrow at each row boundary and o_done after the last row. i_abort
// cancels the job with an o_reset pulse. All outputs are registered.
// Optional feature: define PAD_CTRL_PERF_EN to add the 16-bit o_stall_cnt
// output, a saturating count of stalled RUN cycles.
module pe_pad_ctrl #(
    parameter int ConfDWd  = 4,
    parameter int PConfDWd = 3,
    parameter int CntWd    = 6
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_cfg_valid,
    output logic                o_cfg_ready,
    input  logic [ConfDWd-1:0]  i_cfg_iflen,
    input  logic [ConfDWd-1:0]  i_cfg_popu,
    input  logic [PConfDWd-1:0] i_cfg_pch,
    input  logic [CntWd-1:0]    i_cfg_tw,
    input  logic [CntWd-1:0]    i_cfg_rows,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic                i_stall,
    input  logic                i_wpad_end,
    output logic [ConfDWd-1:0]  o_iflen,
    output logic [ConfDWd-1:0]  o_popu,
    output logic [PConfDWd-1:0] o_pch,
    output logic                o_pop,
    output logic                o_nxtrow,
    output logic                o_start,
    output logic                o_reset,
    output logic                o_done,
    output logic                o_stall,
    output logic                o_busy
`ifdef PAD_CTRL_PERF_EN
    ,
    output logic [15:0]         o_stall_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    localparam logic [CntWd-1:0] CntOne = CntWd'(1);

    logic [1:0]       state, state_nxt;
    logic [CntWd-1:0] pop_cnt, pop_cnt_nxt;
    logic [CntWd-1:0] row_cnt, row_cnt_nxt;
    logic [CntWd-1:0] pop_inc, row_inc;
    logic [CntWd-1:0] tw_q, rows_q;
    logic             cfg_loaded, loaded_nxt;
    logic             cfg_take;
    logic             pop_nxt, nxtrow_nxt, start_nxt, reset_nxt, done_nxt, stall_nxt;

    // A pop can never push pop_cnt past tw_q, nor row_cnt past rows_q,
    // because the terminal compare fires first.
    assign pop_inc  = pop_cnt + CntOne;
    assign row_inc  = row_cnt + CntOne;
    assign cfg_take = (state == IDLE) && i_cfg_valid && o_cfg_ready;

    // Next-state, counter and output-pulse decisions; abort overrides all.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_nxt   = state;
        pop_cnt_nxt = pop_cnt;
        row_cnt_nxt = row_cnt;
        loaded_nxt  = cfg_loaded;
        pop_nxt     = 1'b0;
        nxtrow_nxt  = 1'b0;
        start_nxt   = 1'b0;
        reset_nxt   = 1'b0;
        done_nxt    = 1'b0;
        stall_nxt   = 1'b0;

        if ((state != IDLE) && i_abort) begin
            reset_nxt   = 1'b1;
            pop_cnt_nxt = '0;
            row_cnt_nxt = '0;
            loaded_nxt  = 1'b0;
            state_nxt   = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_take) begin
                        loaded_nxt = 1'b1;
                    end
                    // Only a configuration latched on an earlier cycle arms a job.
                    if (cfg_loaded && i_start) begin
                        state_nxt = ARM;
                    end
                end
                ARM: begin
                    start_nxt   = 1'b1;
                    pop_cnt_nxt = '0;
                    row_cnt_nxt = '0;
                    state_nxt   = RUN;
                end
                RUN: begin
                    if (i_stall) begin
                        stall_nxt = 1'b1;
                    end else if (i_wpad_end) begin
                        pop_nxt = 1'b1;
                        if (pop_inc == tw_q) begin
                            pop_cnt_nxt = '0;
                            row_cnt_nxt = row_inc;
                            if (row_inc == rows_q) begin
                                state_nxt = FIN;
                            end else begin
                                nxtrow_nxt = 1'b1;
                            end
                        end else begin
                            pop_cnt_nxt = pop_inc;
                        end
                    end
                end
                FIN: begin
                    done_nxt   = 1'b1;
                    loaded_nxt = 1'b0;
                    state_nxt  = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, counters and the registered pad control bus.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            pop_cnt     <= '0;
            row_cnt     <= '0;
            cfg_loaded  <= 1'b0;
            o_cfg_ready <= 1'b0;
            o_pop       <= 1'b0;
            o_nxtrow    <= 1'b0;
            o_start     <= 1'b0;
            o_reset     <= 1'b0;
            o_done      <= 1'b0;
            o_stall     <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= state_nxt;
            pop_cnt     <= pop_cnt_nxt;
            row_cnt     <= row_cnt_nxt;
            cfg_loaded  <= loaded_nxt;
            o_cfg_ready <= (state_nxt == IDLE);
            o_busy      <= (state_nxt != IDLE);
            o_pop       <= pop_nxt;
            o_nxtrow    <= nxtrow_nxt;
            o_start     <= start_nxt;
            o_reset     <= reset_nxt;
            o_done      <= done_nxt;
            o_stall     <= stall_nxt;
        end
    end

    // Configuration registers; zero tw/rows are stored as 1.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_iflen <= '0;
            o_popu  <= '0;
            o_pch   <= '0;
            tw_q    <= CntOne;
            rows_q  <= CntOne;
        end else if (cfg_take) begin
            o_iflen <= i_cfg_iflen;
            o_popu  <= i_cfg_popu;
            o_pch   <= i_cfg_pch;
            tw_q    <= (i_cfg_tw == '0) ? CntOne : i_cfg_tw;
            rows_q  <= (i_cfg_rows == '0) ? CntOne : i_cfg_rows;
        end
    end

`ifdef PAD_CTRL_PERF_EN
    // Saturating stall-cycle counter: cleared when a job arms, held afterwards.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_stall_cnt <= '0;
        end else if (start_nxt) begin
            o_stall_cnt <= '0;
        end else if ((state == RUN) && i_stall && !i_abort && (o_stall_cnt != 16'hFFFF)) begin
            o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_pad_ctrl.sv
// tb_pe_pad_ctrl: directed and randomized checks of pe_pad_ctrl against a
// job-level reference model (accepted-pop count versus tw*rows).
// Build with PAD_CTRL_PERF_EN defined to also check o_stall_cnt.
module tb_pe_pad_ctrl;

    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_RUN  = 2;
    localparam int P_FIN  = 3;

    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic       i_cfg_valid = 1'b0;
    logic [3:0] i_cfg_iflen = '0;
    logic [3:0] i_cfg_popu = '0;
    logic [2:0] i_cfg_pch = '0;
    logic [5:0] i_cfg_tw = '0;
    logic [5:0] i_cfg_rows = '0;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic       i_stall = 1'b0;
    logic       i_wpad_end = 1'b0;
    logic       o_cfg_ready;
    logic [3:0] o_iflen, o_popu;
    logic [2:0] o_pch;
    logic       o_pop, o_nxtrow, o_start, o_reset, o_done, o_stall, o_busy;
`ifdef PAD_CTRL_PERF_EN
    logic [15:0] o_stall_cnt;
`endif

    pe_pad_ctrl #(.ConfDWd(4), .PConfDWd(3), .CntWd(6)) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_cfg_valid (i_cfg_valid),
        .o_cfg_ready (o_cfg_ready),
        .i_cfg_iflen (i_cfg_iflen),
        .i_cfg_popu  (i_cfg_popu),
        .i_cfg_pch   (i_cfg_pch),
        .i_cfg_tw    (i_cfg_tw),
        .i_cfg_rows  (i_cfg_rows),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_stall     (i_stall),
        .i_wpad_end  (i_wpad_end),
        .o_iflen     (o_iflen),
        .o_popu      (o_popu),
        .o_pch       (o_pch),
        .o_pop       (o_pop),
        .o_nxtrow    (o_nxtrow),
        .o_start     (o_start),
        .o_reset     (o_reset),
        .o_done      (o_done),
        .o_stall     (o_stall),
        .o_busy      (o_busy)
`ifdef PAD_CTRL_PERF_EN
        ,
        .o_stall_cnt (o_stall_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: job phase, accepted pops versus the job total.
    int          m_where = P_IDLE;
    bit          m_loaded = 1'b0;
    bit          m_ready = 1'b0;
    int          m_tw = 1;
    int          m_total = 1;
    int          m_acc = 0;
    int          m_perf = 0;
    logic [10:0] m_cfg = '0;

    int pops_seen, nxt_seen, done_seen, reset_seen, stall_seen, start_seen;

    function automatic logic [7:0] pad_bus();
        return {o_pop, o_nxtrow, o_start, o_reset, o_done, o_stall, o_busy, o_cfg_ready};
    endfunction

    function automatic logic [10:0] cfg_bus();
        return {o_iflen, o_popu, o_pch};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_seen();
        pops_seen = 0; nxt_seen = 0; done_seen = 0;
        reset_seen = 0; stall_seen = 0; start_seen = 0;
    endtask

    // Predict the effect of the current inputs at the next edge, then compare.
    task automatic cycle(input string tag);
        logic [7:0] e;
        bit pop, nxt, st, rs, dn, sl, was_loaded;
        pop = 0; nxt = 0; st = 0; rs = 0; dn = 0; sl = 0;
        was_loaded = m_loaded;
        if (m_where != P_IDLE && i_abort) begin
            rs = 1; m_where = P_IDLE; m_loaded = 0; m_acc = 0;
        end else begin
            case (m_where)
                P_IDLE: begin
                    if (i_cfg_valid && m_ready) begin
                        m_tw    = (i_cfg_tw == 0) ? 1 : int'(i_cfg_tw);
                        m_total = m_tw * ((i_cfg_rows == 0) ? 1 : int'(i_cfg_rows));
                        m_cfg   = {i_cfg_iflen, i_cfg_popu, i_cfg_pch};
                        m_loaded = 1;
                    end
                    if (was_loaded && i_start) m_where = P_ARM;
                end
                P_ARM: begin
                    st = 1; m_acc = 0; m_perf = 0; m_where = P_RUN;
                end
                P_RUN: begin
                    if (i_stall) begin
                        sl = 1;
                        if (m_perf < 65535) m_perf++;
                    end else if (i_wpad_end) begin
                        pop = 1;
                        m_acc++;
                        if (m_acc == m_total) m_where = P_FIN;
                        else if (m_acc % m_tw == 0) nxt = 1;
                    end
                end
                default: begin
                    dn = 1; m_loaded = 0; m_where = P_IDLE;
                end
            endcase
        end
        m_ready = (m_where == P_IDLE);
        e = {pop, nxt, st, rs, dn, sl, (m_where != P_IDLE), m_ready};
        @(posedge i_clk);
        #1;
        check({tag, " bus"}, 32'(pad_bus()), 32'(e));
        check({tag, " cfg"}, 32'(cfg_bus()), 32'(m_cfg));
`ifdef PAD_CTRL_PERF_EN
        check({tag, " stall_cnt"}, 32'(o_stall_cnt), m_perf);
`endif
        pops_seen  += int'(o_pop);
        nxt_seen   += int'(o_nxtrow);
        done_seen  += int'(o_done);
        reset_seen += int'(o_reset);
        stall_seen += int'(o_stall);
        start_seen += int'(o_start);
    endtask

    task automatic load_cfg(input int tw, input int rows);
        i_cfg_iflen = 4'($urandom_range(0, 15));
        i_cfg_popu  = 4'($urandom_range(0, 15));
        i_cfg_pch   = 3'($urandom_range(0, 7));
        i_cfg_tw    = 6'(tw);
        i_cfg_rows  = 6'(rows);
        i_cfg_valid = 1'b1;
        cycle("cfg_load");
        i_cfg_valid = 1'b0;
        // Scramble the fields so the bench sees whether the pads hold.
        i_cfg_iflen = 4'($urandom_range(0, 15));
        i_cfg_popu  = 4'($urandom_range(0, 15));
        i_cfg_pch   = 3'($urandom_range(0, 7));
    endtask

    // Leaves the DUT in RUN.
    task automatic start_job();
        i_start = 1'b1;
        cycle("start_req");
        i_start = 1'b0;
        cycle("arm");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("reset bus", 32'(pad_bus()), 32'd0);
        check("reset cfg", 32'(cfg_bus()), 32'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        cycle("post_reset");
        check("ready after release", 32'(o_cfg_ready), 32'd1);

        // Start without configuration is ignored
        clear_seen();
        i_start = 1'b1;
        repeat (3) cycle("nocfg_start");
        i_start = 1'b0;
        check("nocfg o_busy", 32'(o_busy), 32'd0);
        check("nocfg o_start seen", start_seen, 0);

        // tw=3 rows=2: six pops, one nxtrow, then done
        load_cfg(3, 2);
        clear_seen();
        start_job();
        repeat (6) begin
            i_wpad_end = 1'b1;
            cycle("job_pop");
            i_wpad_end = 1'b0;
            cycle("job_gap");
        end
        cycle("job_idle");
        check("job pops", pops_seen, 6);
        check("job nxtrow", nxt_seen, 1);
        check("job done", done_seen, 1);
        check("job start", start_seen, 1);

        // Stall for 4 cycles with wpad_end held, then abort with wpad_end
        load_cfg(5, 2);
        start_job();
        clear_seen();
        i_wpad_end = 1'b1;
        i_stall = 1'b1;
        repeat (4) cycle("stall");
        check("stall no pop", pops_seen, 0);
        i_stall = 1'b0;
        cycle("stall_release");
        check("stall cycles", stall_seen, 4);
        check("release pop", pops_seen, 1);
`ifdef PAD_CTRL_PERF_EN
        check("stall_cnt value", 32'(o_stall_cnt), 32'd4);
`endif
        i_abort = 1'b1;
        cycle("abort");
        i_abort = 1'b0;
        i_wpad_end = 1'b0;
        check("abort pops", pops_seen, 1);
        check("abort reset", reset_seen, 1);
        check("abort ready", 32'(o_cfg_ready), 32'd1);
        cycle("abort_idle");
        i_start = 1'b1;
        cycle("abort_restart");
        i_start = 1'b0;
        check("abort unloaded", 32'(o_busy), 32'd0);

        // tw=0 rows=0 behaves as a single pop job
        load_cfg(0, 0);
        start_job();
        clear_seen();
        i_wpad_end = 1'b1;
        cycle("unit_pop");
        i_wpad_end = 1'b0;
        cycle("unit_done");
        cycle("unit_idle");
        check("unit pops", pops_seen, 1);
        check("unit done", done_seen, 1);
        check("unit nxtrow", nxt_seen, 0);

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            int c;
            load_cfg(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
            i_start = 1'b1;
            cycle("rand_start");
            i_start = 1'b0;
            c = 0;
            while (m_where != P_IDLE && c < 300) begin
                i_stall    = ($urandom_range(0, 3) == 0);
                i_wpad_end = 1'($urandom_range(0, 1));
                i_abort    = ($urandom_range(0, 80) == 0);
                cycle("rand");
                c++;
            end
            i_stall = 1'b0; i_wpad_end = 1'b0; i_abort = 1'b0;
            cycle("rand_idle");
            check("rand back to idle", 32'(o_cfg_ready), 32'd1);
        end

        // Asynchronous reset in the middle of RUN
        load_cfg(4, 3);
        start_job();
        i_wpad_end = 1'b1;
        repeat (2) cycle("pre_rst_pop");
        i_wpad_end = 1'b0;
        clear_seen();
        i_rstn = 1'b0;
        #2;
        check("async_rst bus", 32'(pad_bus()), 32'd0);
        check("async_rst cfg", 32'(cfg_bus()), 32'd0);
        m_where = P_IDLE; m_loaded = 0; m_ready = 0; m_acc = 0; m_perf = 0; m_cfg = '0;
        @(posedge i_clk);
        #1;
        check("rst_hold bus", 32'(pad_bus()), 32'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        cycle("rst_release");
        check("rst ready", 32'(o_cfg_ready), 32'd1);
        i_start = 1'b1;
        cycle("rst_restart");
        i_start = 1'b0;
        cycle("rst_idle");
        check("rst no done", done_seen, 0);
        check("rst no reset", reset_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
